// File: rtl/rpn_stack_sequencer.sv
// -----------------------------------------------------------------------------
// rpn_stack_sequencer
//
// Small reverse-polish calculator stack. Operands are pushed with `enter`.
// An `op_valid` pulse pops two operands (B = top, then A = the deeper one),
// computes R = A op B and pushes R back, taking one cycle per step:
// POP_B -> POP_A -> EXEC -> PUSH_R.
//
// Handshake: enter/op_valid/clear are single-cycle command pulses sampled on
// the rising edge of CLOCK_50. A command is only acted on while the sequencer
// is IDLE (busy=0). Commands arriving while busy=1 are silently dropped.
// clear always wins. op_valid wins over enter in the same cycle.
//
// Ports
//   CLOCK_50   in   clock, rising edge
//   RESETN     in   asynchronous active-low reset
//   enter      in   push data_in
//   data_in    in   [WIDTH] operand
//   op_valid   in   start an operation using op_code
//   op_code    in   [2] 00 add, 01 sub, 10 mul, 11 and
//   clear      in   synchronous clear of stack and sticky flags
//   top        out  [WIDTH] top-of-stack (0 when empty)
//   depth      out  [clog2(DEPTH+1)] number of valid entries
//   busy       out  operation sequence in progress
//   done       out  one-cycle pulse when a result is pushed
//   overflow   out  sticky: push attempted while full
//   underflow  out  sticky: op attempted with fewer than two entries
//   state_dbg  out  [3] current FSM state, for observation only
// -----------------------------------------------------------------------------
module rpn_stack_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         CLOCK_50,
    input  logic                         RESETN,
    input  logic                         enter,
    input  logic [WIDTH-1:0]             data_in,
    input  logic                         op_valid,
    input  logic [1:0]                   op_code,
    input  logic                         clear,
    output logic [WIDTH-1:0]             top,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic                         underflow,
    output logic [2:0]                   state_dbg
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP_B  = 3'd1,
        POP_A  = 3'd2,
        EXEC   = 3'd3,
        PUSH_R = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic [1:0]        op_q, op_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    // Storage has no reset: slots at or above depth are never shown on top.
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [WIDTH-1:0]  wr_data;

    logic [WIDTH-1:0]  stored_top;
    logic              is_full;
    logic              has_two;

    assign stored_top = (depth_q == '0) ? '0 : mem_q[AW'(depth_q - 1'b1)];
    assign is_full    = (depth_q == DW'(DEPTH));
    assign has_two    = (depth_q >= DW'(2));

    // ------------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        op_d    = op_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        wr_en   = 1'b0;
        wr_addr = AW'(depth_q);
        wr_data = data_in;

        if (clear) begin
            state_d = IDLE;
            depth_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (op_valid) begin
                        // enter in the same cycle is dropped on purpose
                        if (has_two) begin
                            op_d    = op_code;
                            state_d = POP_B;
                        end else begin
                            unf_d = 1'b1;
                        end
                    end else if (enter) begin
                        if (is_full) begin
                            ovf_d = 1'b1;
                        end else begin
                            wr_en   = 1'b1;
                            depth_d = depth_q + 1'b1;
                        end
                    end
                end
                POP_B: begin
                    b_d     = stored_top;
                    depth_d = depth_q - 1'b1;
                    state_d = POP_A;
                end
                POP_A: begin
                    a_d     = stored_top;
                    depth_d = depth_q - 1'b1;
                    state_d = EXEC;
                end
                EXEC: begin
                    unique case (op_q)
                        2'b00:   r_d = a_q + b_q;
                        2'b01:   r_d = a_q - b_q;
                        2'b10:   r_d = a_q * b_q;
                        default: r_d = a_q & b_q;
                    endcase
                    state_d = PUSH_R;
                end
                PUSH_R: begin
                    // Outputs already show R during this state; commit it here.
                    wr_en   = 1'b1;
                    wr_data = r_q;
                    depth_d = depth_q + 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
            depth_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            op_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            op_q    <= op_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. During PUSH_R the pending result is presented as already
    // pushed so top/depth/done all change in the same cycle.
    // ------------------------------------------------------------------------
    assign top       = (state_q == PUSH_R) ? r_q : stored_top;
    assign depth     = (state_q == PUSH_R) ? depth_q + 1'b1 : depth_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == PUSH_R);
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_rpn_stack_sequencer.sv
module tb_rpn_stack_sequencer;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       CLOCK_50 = 1'b0;
  logic       RESETN;
  logic       enter;
  logic [7:0] data_in;
  logic       op_valid;
  logic [1:0] op_code;
  logic       clear;
  logic [7:0] top;
  logic [2:0] depth;
  logic       busy;
  logic       done;
  logic       overflow;
  logic       underflow;
  logic [2:0] state_dbg;

  always #5 CLOCK_50 = ~CLOCK_50;

  rpn_stack_sequencer #(.WIDTH(8), .DEPTH(4)) dut (
    .CLOCK_50  (CLOCK_50),
    .RESETN    (RESETN),
    .enter     (enter),
    .data_in   (data_in),
    .op_valid  (op_valid),
    .op_code   (op_code),
    .clear     (clear),
    .top       (top),
    .depth     (depth),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .underflow (underflow),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / reference model: the stack is a plain queue, last = top.
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  bit         m_ovf;
  bit         m_unf;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [7:0] m_top();
    return (exp_q.size() == 0) ? 8'h00 : exp_q[$];
  endfunction

  function automatic logic [7:0] m_calc(input int code, input int a, input int b);
    int r;
    case (code)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a * b;
      default: r = a & b;
    endcase
    return 8'(r & 255);
  endfunction

  // Step to just after the next active edge.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_top"},   top,       m_top());
    check({tag, "_depth"}, depth,     exp_q.size());
    check({tag, "_ovf"},   overflow,  m_ovf);
    check({tag, "_unf"},   underflow, m_unf);
    check({tag, "_busy"},  busy,      0);
    check({tag, "_done"},  done,      0);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic push(input logic [7:0] v);
    enter   = 1'b1;
    data_in = v;
    tick();
    enter   = 1'b0;
    if (exp_q.size() < 4) exp_q.push_back(v);
    else m_ovf = 1'b1;
    check_idle("push");
  endtask

  task automatic do_clear(input bit with_others);
    clear = 1'b1;
    if (with_others) begin
      enter    = 1'b1;
      op_valid = 1'b1;
      data_in  = 8'($urandom);
    end
    tick();
    clear    = 1'b0;
    enter    = 1'b0;
    op_valid = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_idle("clear");
  endtask

  task automatic run_op(input int code, input bit with_enter, input bit enter_busy);
    int n;
    logic [7:0] a, b, r;
    op_valid = 1'b1;
    op_code  = 2'(code);
    if (with_enter) begin
      enter   = 1'b1;
      data_in = 8'($urandom);
    end
    tick();
    op_valid = 1'b0;
    enter    = 1'b0;
    op_code  = 2'($urandom);   // must not affect an accepted op
    if (exp_q.size() < 2) begin
      m_unf = 1'b1;
      check_idle("op_unf");
      tick();
      check("op_unf_busy2", busy, 0);
      check("op_unf_done2", done, 0);
      return;
    end
    n = exp_q.size();
    b = exp_q.pop_back();
    a = exp_q.pop_back();
    r = m_calc(code, a, b);
    check("op_c1_busy",  busy,  1);
    check("op_c1_depth", depth, n);
    check("op_c1_done",  done,  0);
    if (enter_busy) begin
      enter   = 1'b1;
      data_in = 8'($urandom);
      op_valid = 1'b1;
    end
    tick();
    enter    = 1'b0;
    op_valid = 1'b0;
    check("op_c2_busy",  busy,  1);
    check("op_c2_depth", depth, n - 1);
    tick();
    check("op_c3_busy",  busy,  1);
    check("op_c3_depth", depth, n - 2);
    check("op_c3_done",  done,  0);
    tick();
    check("op_c4_done",  done,  1);
    check("op_c4_busy",  busy,  1);
    check("op_c4_top",   top,   r);
    check("op_c4_depth", depth, n - 1);
    exp_q.push_back(r);
    tick();
    check_idle("op_after");
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    RESETN   = 1'b0;
    enter    = 1'b0;
    op_valid = 1'b0;
    clear    = 1'b0;
    data_in  = '0;
    op_code  = '0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    #3;
    check_idle("reset");
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    RESETN = 1'b1;

    // First edge after release accepts the push.
    push(8'd5);
    push(8'd3);
    run_op(0, 1'b0, 1'b0);
    check("add_top", top, 8);

    do_clear(1'b0);
    push(8'd3);
    push(8'd5);
    run_op(1, 1'b0, 1'b0);
    check("sub_wrap", top, 8'hFE);
    do_clear(1'b0);
    push(8'h20);
    push(8'h10);
    run_op(2, 1'b0, 1'b0);
    check("mul_trunc", top, 8'h00);

    do_clear(1'b0);
    for (int i = 1; i <= 4; i++) push(8'(i));
    push(8'd9);
    check("ovf_flag", overflow, 1);
    check("ovf_top",  top,      4);
    do_clear(1'b0);

    push(8'd7);
    run_op(0, 1'b0, 1'b0);
    check("unf_flag", underflow, 1);

    do_clear(1'b0);
    push(8'd12);
    push(8'd10);
    run_op(3, 1'b1, 1'b1);

    // Reset in the middle of EXEC.
    do_clear(1'b0);
    push(8'd6);
    push(8'd2);
    op_valid = 1'b1;
    op_code  = 2'd0;
    tick();
    op_valid = 1'b0;
    tick();
    tick();
    #2;
    RESETN = 1'b0;
    #1;
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_idle("async_rst");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_done", done, 0);
    end
    @(negedge CLOCK_50);
    RESETN = 1'b1;
    push(8'h11);
    check("rst_push_depth", depth, 1);
    for (int i = 0; i < 6; i++) begin
      check("post_rst_no_done", done, 0);
      tick();
    end

    // Randomized traffic against the queue model.
    repeat (200) begin
      int sel;
      sel = $urandom_range(0, 12);
      if (sel <= 5) push(8'($urandom));
      else if (sel <= 11) run_op($urandom_range(0, 3), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
      else do_clear(1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
